mem_ctrl: RTL and testbench

Byte-serial memory controller inside `cpu`. It shares the single 8-bit memory port (`mem_a`/`mem_dout`/`mem_wr`/`mem_din`) between two requesters:

- the instruction fetch unit: 32-bit reads;
- the load/store unit: 1/2/4-byte reads and writes.

It sequences each multi-byte access, honours the `en` stall from the top level, and throttles writes to the I/O region while the UART buffer is full.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the byte-serial memory controller.
package mem_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Load/store size codes; 2'b11 is handled as a word
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Top two RAM address bits that select the I/O region
    localparam logic [1:0] IO_REGION = 2'b11;

    // Which requester owns the current transaction
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Number of bytes moved for a given size code
    function automatic logic [2:0] size_to_len(input logic [1:0] sz);
        logic [2:0] len;
        case (sz)
            SZ_BYTE: len = 3'd1;
            SZ_HALF: len = 3'd2;
            SZ_WORD: len = 3'd4;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: shares one 8-bit memory port between the
// instruction fetch unit (32-bit reads) and the load/store unit (1/2/4-byte
// reads and writes). All memory-port outputs come straight from registers.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic        busy
);

    logic [1:0]  r_state;
    owner_e      r_owner;
    logic [31:0] r_addr;
    logic [2:0]  r_len;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic [2:0]  r_idx;      // byte index on the bus (read issue / write k)
    logic [2:0]  r_cnt;      // bytes captured so far on a read
    logic        r_iss_vld;  // mem_a carries a real read issue this cycle
    logic        r_cap_vld;  // mem_din answers an issue made while we owned the bus
    logic [31:0] r_mem_a;
    logic [7:0]  r_mem_dout;
    logic        r_mem_wr;
    logic        r_if_done;
    logic        r_ls_done;
    logic [31:0] r_if_data;
    logic [31:0] r_ls_rdata;

    logic        w_flush_fetch;
    logic        w_cap;
    logic [2:0]  w_cnt_nx;
    logic [31:0] w_data_nx;
    logic        w_rd_last;
    logic [2:0]  w_k_nx;
    logic        w_wr_last;
    logic [31:0] w_wr_addr;
    logic [7:0]  w_wr_byte;
    logic        w_wr_stall;
    logic        w_acc_stall;

    // Next-value helpers for byte capture and byte write sequencing
    always_comb begin
        w_flush_fetch = flush && (r_owner == OWN_IF) &&
                        ((r_state == ST_READ) || (r_state == ST_DONE));
        w_cap     = (r_state == ST_READ) && r_cap_vld;
        w_cnt_nx  = r_cnt + {2'b00, w_cap};
        w_rd_last = (w_cnt_nx == r_len);

        // Byte-assembly register: the captured byte lands in lane r_cnt
        w_data_nx = r_data;
        if (w_cap) begin
            case (r_cnt[1:0])
                2'd0:    w_data_nx[7:0]   = mem_din;
                2'd1:    w_data_nx[15:8]  = mem_din;
                2'd2:    w_data_nx[23:16] = mem_din;
                default: w_data_nx[31:24] = mem_din;
            endcase
        end

        // A write completes when its strobe was on the bus in an owned cycle
        w_k_nx    = r_idx + {2'b00, r_mem_wr};
        w_wr_last = (w_k_nx == r_len);
        w_wr_addr = r_addr + {29'd0, w_k_nx};
        case (w_k_nx[1:0])
            2'd0:    w_wr_byte = r_wdata[7:0];
            2'd1:    w_wr_byte = r_wdata[15:8];
            2'd2:    w_wr_byte = r_wdata[23:16];
            default: w_wr_byte = r_wdata[31:24];
        endcase
        w_wr_stall  = (w_wr_addr[RAM_ADDR_WIDTH -: 2] == IO_REGION) && io_buffer_full;
        w_acc_stall = (ls_addr[RAM_ADDR_WIDTH -: 2] == IO_REGION) && io_buffer_full;
    end

    // Transaction FSM, bus drive and done/data output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_IF;
            r_addr     <= '0;
            r_len      <= '0;
            r_wdata    <= '0;
            r_data     <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_iss_vld  <= 1'b0;
            r_cap_vld  <= 1'b0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= '0;
            r_ls_rdata <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            if (w_flush_fetch) begin
                // Abandon the fetch and idle the bus; its data is never reported
                r_state    <= ST_IDLE;
                r_mem_a    <= '0;
                r_mem_dout <= '0;
                r_mem_wr   <= 1'b0;
                r_iss_vld  <= 1'b0;
                r_cap_vld  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (en && (ls_req || (if_req && !flush))) begin
                            r_data    <= '0;
                            r_idx     <= '0;
                            r_cnt     <= '0;
                            r_cap_vld <= 1'b0;
                            if (ls_req) begin
                                r_owner <= OWN_LS;
                                r_addr  <= ls_addr;
                                r_len   <= size_to_len(ls_size);
                                r_wdata <= ls_wdata;
                                if (ls_wr) begin
                                    r_state   <= ST_WRITE;
                                    r_iss_vld <= 1'b0;
                                    if (w_acc_stall) begin
                                        r_mem_a    <= '0;
                                        r_mem_dout <= '0;
                                        r_mem_wr   <= 1'b0;
                                    end else begin
                                        r_mem_a    <= ls_addr;
                                        r_mem_dout <= ls_wdata[7:0];
                                        r_mem_wr   <= 1'b1;
                                    end
                                end else begin
                                    r_state   <= ST_READ;
                                    r_mem_a   <= ls_addr;
                                    r_iss_vld <= 1'b1;
                                end
                            end else begin
                                r_owner   <= OWN_IF;
                                r_addr    <= if_addr;
                                r_len     <= 3'd4;
                                r_state   <= ST_READ;
                                r_mem_a   <= if_addr;
                                r_iss_vld <= 1'b1;
                            end
                        end
                    end

                    ST_READ: begin
                        if (w_cap) begin
                            r_data <= w_data_nx;
                            r_cnt  <= w_cnt_nx;
                        end
                        if (!en) begin
                            // Frozen: park the first uncaptured byte so it is
                            // re-issued on the first cycle the bus is back
                            r_cap_vld <= 1'b0;
                            r_idx     <= w_cnt_nx;
                            if (w_rd_last) begin
                                r_mem_a   <= '0;
                                r_iss_vld <= 1'b0;
                            end else begin
                                r_mem_a   <= r_addr + {29'd0, w_cnt_nx};
                                r_iss_vld <= 1'b1;
                            end
                        end else if (w_rd_last) begin
                            r_state   <= ST_DONE;
                            r_mem_a   <= '0;
                            r_iss_vld <= 1'b0;
                            r_cap_vld <= 1'b0;
                            if (r_owner == OWN_IF) begin
                                r_if_done <= 1'b1;
                                r_if_data <= w_data_nx;
                            end else begin
                                r_ls_done  <= 1'b1;
                                r_ls_rdata <= w_data_nx;
                            end
                        end else begin
                            r_cap_vld <= r_iss_vld;
                            if (r_iss_vld && ((r_idx + 3'd1) < r_len)) begin
                                r_idx     <= r_idx + 3'd1;
                                r_mem_a   <= r_addr + {29'd0, r_idx + 3'd1};
                                r_iss_vld <= 1'b1;
                            end else begin
                                r_mem_a   <= '0;
                                r_iss_vld <= 1'b0;
                            end
                        end
                    end

                    ST_WRITE: begin
                        if (!en) begin
                            // Frozen: the pending byte is retried once en returns
                            r_mem_a    <= '0;
                            r_mem_dout <= '0;
                            r_mem_wr   <= 1'b0;
                        end else if (w_wr_last) begin
                            r_state    <= ST_DONE;
                            r_mem_a    <= '0;
                            r_mem_dout <= '0;
                            r_mem_wr   <= 1'b0;
                            r_ls_done  <= 1'b1;
                        end else begin
                            r_idx <= w_k_nx;
                            if (w_wr_stall) begin
                                r_mem_a    <= '0;
                                r_mem_dout <= '0;
                                r_mem_wr   <= 1'b0;
                            end else begin
                                r_mem_a    <= w_wr_addr;
                                r_mem_dout <= w_wr_byte;
                                r_mem_wr   <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        // DONE: requests are not sampled here
                        if (en) begin
                            r_state <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign mem_wr   = r_mem_wr;
    assign if_done  = r_if_done && !flush;
    assign if_data  = r_if_data;
    assign ls_done  = r_ls_done;
    assign ls_rdata = r_ls_rdata;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide memory model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req, ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int base;

    logic [7:0] ram [0:4095];

    always #5 clk = ~clk;

    mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .busy(busy)
    );

    // Fold the few addresses used here into a small array
    function automatic logic [11:0] idx(input logic [31:0] a);
        return {a[17:16], a[13:12], a[7:0]};
    endfunction

    // Memory: read data one cycle after the address; junk while debug owns the bus
    always @(posedge clk) begin
        if (en) mem_din <= ram[idx(mem_a)];
        else    mem_din <= 8'hEE;
        if (en && mem_wr) begin
            ram[idx(mem_a)] <= mem_dout;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
        io_buffer_full = 1'b0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[idx(32'h1000)] = 8'h93; ram[idx(32'h1001)] = 8'h85;
        ram[idx(32'h1002)] = 8'hc5; ram[idx(32'h1003)] = 8'h00;
        ram[idx(32'h2000)] = 8'hEF; ram[idx(32'h2001)] = 8'hBE;
        ram[idx(32'h2002)] = 8'hAD; ram[idx(32'h2003)] = 8'hDE;
        ram[idx(32'h0020)] = 8'h34; ram[idx(32'h0021)] = 8'h12;
        ram[idx(32'h0040)] = 8'h11; ram[idx(32'h0041)] = 8'h22;
        ram[idx(32'h0042)] = 8'h33; ram[idx(32'h0043)] = 8'h44;

        // Reset state
        cyc(); cyc();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_ls_done", {31'd0, ls_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        rst = 1'b0;
        cyc();

        // Fetch of 0x00c58593 at 0x1000
        if_req = 1'b1; if_addr = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("fetch_addr", mem_a, 32'h1000 + k);
        end
        chk("fetch_no_wr", {31'd0, mem_wr}, 32'd0);
        cyc();
        chk("fetch_done_early", {31'd0, if_done}, 32'd0);
        cyc();
        chk("fetch_done", {31'd0, if_done}, 32'd1);
        chk("fetch_data", if_data, 32'h00c58593);
        if_req = 1'b0;
        cyc();
        chk("fetch_idle", {31'd0, busy}, 32'd0);
        chk("fetch_done_pulse", {31'd0, if_done}, 32'd0);

        // Simultaneous requests: load-half wins, fetch follows
        if_req = 1'b1; if_addr = 32'h1000;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b01; ls_addr = 32'h20;
        cyc(); chk("arb_a0", mem_a, 32'h20);
        cyc(); chk("arb_a1", mem_a, 32'h21);
        cyc(); chk("arb_ls_early", {31'd0, ls_done}, 32'd0);
        cyc();
        chk("arb_ls_done", {31'd0, ls_done}, 32'd1);
        chk("arb_ls_rdata", ls_rdata, 32'h00001234);
        chk("arb_if_quiet", {31'd0, if_done}, 32'd0);
        ls_req = 1'b0;
        cyc(); chk("arb_idle", {31'd0, busy}, 32'd0);
        cyc(); chk("arb_fetch_a0", mem_a, 32'h1000);
        repeat (4) cyc();
        cyc();
        chk("arb_if_done", {31'd0, if_done}, 32'd1);
        chk("arb_if_data", if_data, 32'h00c58593);
        if_req = 1'b0;
        cyc();

        // I/O store with the UART buffer full for three cycles
        base = wr_count;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b00;
        ls_addr = 32'h30000; ls_wdata = 32'hAABBCC41; io_buffer_full = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("io_stall_wr", {31'd0, mem_wr}, 32'd0);
            chk("io_stall_a", mem_a, 32'd0);
        end
        io_buffer_full = 1'b0;
        cyc();
        chk("io_wr", {31'd0, mem_wr}, 32'd1);
        chk("io_a", mem_a, 32'h30000);
        chk("io_dout", {24'd0, mem_dout}, 32'h41);
        cyc();
        chk("io_done", {31'd0, ls_done}, 32'd1);
        chk("io_after_wr", {31'd0, mem_wr}, 32'd0);
        chk("io_after_a", mem_a, 32'd0);
        ls_req = 1'b0; ls_wr = 1'b0;
        cyc();
        chk("io_wr_count", wr_count - base, 32'd1);
        chk("io_ram", {24'd0, ram[idx(32'h30000)]}, 32'h41);

        // Flush mid-fetch, then a new fetch once flush drops
        if_req = 1'b1; if_addr = 32'h1000;
        cyc(); chk("fl_a0", mem_a, 32'h1000);
        cyc(); chk("fl_a1", mem_a, 32'h1001);
        flush = 1'b1; if_addr = 32'h2000;
        cyc();
        chk("fl_bus_idle", mem_a, 32'd0);
        chk("fl_busy", {31'd0, busy}, 32'd0);
        chk("fl_no_done", {31'd0, if_done}, 32'd0);
        cyc();
        chk("fl_no_accept", mem_a, 32'd0);
        flush = 1'b0;
        cyc(); chk("fl_new_a0", mem_a, 32'h2000);
        repeat (4) cyc();
        chk("fl_new_early", {31'd0, if_done}, 32'd0);
        cyc();
        chk("fl_new_done", {31'd0, if_done}, 32'd1);
        chk("fl_new_data", if_data, 32'hDEADBEEF);
        if_req = 1'b0;
        cyc();

        // en low in T+3..T+5 of a word load
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h40;
        cyc(); chk("en_a0", mem_a, 32'h40);
        cyc(); chk("en_a1", mem_a, 32'h41);
        cyc(); chk("en_a2", mem_a, 32'h42);
        en = 1'b0;
        cyc();
        chk("en_frozen_wr", {31'd0, mem_wr}, 32'd0);
        chk("en_frozen_busy", {31'd0, busy}, 32'd1);
        cyc();
        cyc();
        chk("en_reissue", mem_a, 32'h42);
        en = 1'b1;
        cyc(); chk("en_a3", mem_a, 32'h43);
        cyc(); chk("en_done_early", {31'd0, ls_done}, 32'd0);
        cyc();
        chk("en_done", {31'd0, ls_done}, 32'd1);
        chk("en_rdata", ls_rdata, 32'h44332211);
        ls_req = 1'b0;
        cyc();

        // Reset during the second byte of a word store
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10;
        ls_addr = 32'h80; ls_wdata = 32'h04030201;
        cyc();
        chk("rw_wr0", {31'd0, mem_wr}, 32'd1);
        chk("rw_a0", mem_a, 32'h80);
        chk("rw_d0", {24'd0, mem_dout}, 32'h01);
        cyc();
        chk("rw_a1", mem_a, 32'h81);
        chk("rw_d1", {24'd0, mem_dout}, 32'h02);
        rst = 1'b1;
        cyc();
        chk("rw_rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rw_rst_a", mem_a, 32'd0);
        chk("rw_rst_dout", {24'd0, mem_dout}, 32'd0);
        chk("rw_rst_busy", {31'd0, busy}, 32'd0);
        chk("rw_rst_ls_done", {31'd0, ls_done}, 32'd0);
        chk("rw_rst_rdata", ls_rdata, 32'd0);
        chk("rw_rst_if_data", if_data, 32'd0);
        base = wr_count;
        rst = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
        cyc(); cyc();
        chk("rw_no_more_wr", wr_count - base, 32'd0);
        chk("rw_idle_wr", {31'd0, mem_wr}, 32'd0);
        chk("rw_ram1", {24'd0, ram[idx(32'h81)]}, 32'h02);
        chk("rw_ram2", {24'd0, ram[idx(32'h82)]}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
